// File: rtl/pc_uart_tx_feeder_if.sv
// Bundle of system-side write and transmitter-side signals for pc_uart_tx_feeder.
//   master : the system/bench side. It drives the write, flush and overflow-clear requests.
//   slave  : the feeder. It drives wr_ready, tx_data, trigger, busy, fifo_count and overflow.
interface pc_uart_tx_feeder_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [7:0]      wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic            flush;
    logic            ovf_clr;
    logic [7:0]      tx_data;
    logic            trigger;
    logic            busy;
    logic [ADDR_W:0] fifo_count;
    logic            overflow;

    modport master (
        output wr_data, wr_valid, flush, ovf_clr,
        input  wr_ready, tx_data, trigger, busy, fifo_count, overflow
    );

    modport slave (
        input  wr_data, wr_valid, flush, ovf_clr,
        output wr_ready, tx_data, trigger, busy, fifo_count, overflow
    );
endinterface

// File: rtl/pc_uart_tx_feeder.sv
// Byte FIFO and frame sequencer in front of the PC UART transmitter.
// The block buffers bytes from the system side and presents one byte at a time on tx_data.
// It pulses trigger once per byte. It then waits FRAME_CLKS cycles so that the transmitter
// finishes a whole frame before the next trigger.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active-high
//   bus    slave modport of pc_uart_tx_feeder_if:
//            wr_data/wr_valid/wr_ready  enqueue handshake (the byte is accepted when both
//                                       wr_valid and wr_ready are high)
//            flush                      synchronous FIFO clear
//            ovf_clr                    clears the sticky overflow flag
//            tx_data                    current byte; stable from one load until the next
//            trigger                    1-cycle start pulse to the transmitter
//            busy                       sequencer not idle
//            fifo_count                 bytes queued (0..DEPTH)
//            overflow                   sticky flag: a write was attempted while full
module pc_uart_tx_feeder #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FRAME_CLKS = 22   // 1..255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_uart_tx_feeder_if.slave    bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StTrig, StWait} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          tx_q, tx_d;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                ovf_q;

    logic                wr_ready;
    logic                push;
    logic                pop;

    // wr_ready looks only at the current count. A pop on the same edge does not free a slot.
    assign wr_ready = (count_q != (ADDR_W+1)'(DEPTH));
    // flush wins over a simultaneous write and over a pop.
    assign push     = bus.wr_valid & wr_ready & ~bus.flush;
    assign pop      = (state_q == StIdle) & (count_q != '0) & ~bus.flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tx_d    = mem[rd_ptr_q];
                    state_d = StTrig;
                end
            end
            StTrig: begin
                cnt_d   = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 8'(FRAME_CLKS - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            tx_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (ADDR_W+1)'(1);
            end
        end
    end

    // Storage array has no reset. Reading an entry is qualified by a nonzero count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.wr_data;
    end

    // A rejected write sets the flag. Setting wins over ovf_clr on the same edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_valid && !wr_ready && !bus.flush) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.tx_data    = tx_q;
    assign bus.trigger    = (state_q == StTrig);
    assign bus.busy       = (state_q != StIdle);
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_pc_uart_tx_feeder.sv
// Self-checking bench for pc_uart_tx_feeder. A queue-based reference model predicts every
// output on every cycle. The model holds the queued bytes and counts down the cycles left
// in the current frame. A small UART receiver rebuilds each frame from tx_data after every
// trigger. The bytes it rebuilds are compared with the bytes the model popped.
module tb_pc_uart_tx_feeder;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned FRAME_CLKS = 22;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pc_uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    pc_uart_tx_feeder #(
        .ADDR_W     (ADDR_W),
        .FRAME_CLKS (FRAME_CLKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_tx;
    int         m_left;      // cycles of TRIG+WAIT remaining; 0 means idle
    logic       m_ovf;
    logic [7:0] exp_rx[$];
    logic [7:0] got_rx[$];
    int         trig_times[$];

    // UART receiver model, 2 clocks per bit, 10 bits per frame
    bit         u_active;
    int         u_cyc;
    logic [7:0] u_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("tx_data",    32'(bus.tx_data),    32'(m_tx));
        check("trigger",    32'(bus.trigger),    32'(m_left == int'(FRAME_CLKS) + 1));
        check("busy",       32'(bus.busy),       32'(m_left != 0));
        check("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
        check("wr_ready",   32'(bus.wr_ready),   32'(q.size() != DEPTH));
        check("overflow",   32'(bus.overflow),   32'(m_ovf));
    endtask

    task automatic uart_step();
        int b;
        logic line;
        if (u_active) begin
            u_cyc++;
            b = (u_cyc - 1) / 2;
            if (((u_cyc - 1) % 2) == 1) begin
                line = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bus.tx_data[b-1];
                if (b >= 1 && b <= 8) u_byte[b-1] = line;
                if (b == 9) begin
                    got_rx.push_back(u_byte);
                    u_active = 1'b0;
                end
            end
        end
        if (bus.trigger) begin
            u_active = 1'b1;
            u_cyc    = 0;
            trig_times.push_back(cyc);
        end
    endtask

    // Advance the model using the inputs now applied. Then clock the DUT and compare.
    task automatic tick();
        bit ready, pop, push;
        if (rst_n) begin
            q.delete();
            m_tx   = 8'h00;
            m_left = 0;
            m_ovf  = 1'b0;
            exp_rx.delete();
            got_rx.delete();
        end else begin
            ready = (q.size() != DEPTH);
            pop   = (m_left == 0) && (q.size() != 0) && !bus.flush;
            push  = bus.wr_valid && ready && !bus.flush;
            if (bus.wr_valid && !ready && !bus.flush) m_ovf = 1'b1;
            else if (bus.ovf_clr)                     m_ovf = 1'b0;
            if (m_left > 0) m_left--;
            if (pop) begin
                m_tx   = q.pop_front();
                exp_rx.push_back(m_tx);
                m_left = FRAME_CLKS + 1;
            end
            if (bus.flush)  q.delete();
            else if (push)  q.push_back(bus.wr_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (rst_n) u_active = 1'b0;
        else       uart_step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_rx_count"}, 32'(got_rx.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++) begin
            check({tag, "_rx_byte"}, 32'(got_rx[i]), 32'(exp_rx[i]));
        end
        exp_rx.delete();
        got_rx.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.wr_data  = 8'h00;
        bus.wr_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ovf_clr  = 1'b0;
        m_tx = 8'h00; m_left = 0; m_ovf = 1'b0; u_active = 1'b0; u_cyc = 0; u_byte = 8'h00;

        // Reset state
        ticks(3);
        rst_n = 1'b0;
        ticks(2);

        // Single byte: the trigger comes one edge after accept; busy lasts 23 cycles
        trig_times.delete();
        push_byte(8'hA5);
        ticks(30);
        check("a5_one_trigger", 32'(trig_times.size()), 32'd1);
        check("a5_decoded", (got_rx.size() > 0) ? 32'(got_rx[0]) : 32'hFFFF, 32'hA5);
        compare_rx("a5");

        // Three back-to-back bytes: triggers exactly 24 cycles apart
        trig_times.delete();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        ticks(80);
        check("b2b_triggers", 32'(trig_times.size()), 32'd3);
        if (trig_times.size() == 3) begin
            check("b2b_space1", 32'(trig_times[1] - trig_times[0]), 32'd24);
            check("b2b_space2", 32'(trig_times[2] - trig_times[1]), 32'd24);
        end
        check("b2b_rx_n", 32'(got_rx.size()), 32'd3);
        if (got_rx.size() == 3) begin
            check("b2b_rx0", 32'(got_rx[0]), 32'h11);
            check("b2b_rx1", 32'(got_rx[1]), 32'h22);
            check("b2b_rx2", 32'(got_rx[2]), 32'h33);
        end
        compare_rx("b2b");

        // Fill the FIFO while the sequencer is busy so that overflow is set
        for (int i = 0; i < 18; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'h40 + i);
            tick();
        end
        bus.wr_valid = 1'b0;
        check("full_count", 32'(bus.fifo_count), 32'd16);
        check("full_ovf", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hDD;
        tick();
        check("ovf_set_wins", 32'(bus.overflow), 32'd1);
        bus.ovf_clr  = 1'b0;
        bus.wr_valid = 1'b0;

        // Write while full on the same edge as a pop: the write is rejected
        guard = 0;
        while (m_left != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("idle_reached", 32'(guard < 100), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        tick();
        bus.wr_valid = 1'b0;
        check("pop_vs_full_write", 32'(bus.fifo_count), 32'd15);
        ticks(16 * 24 + 10);
        compare_rx("fill");

        // Flush during WAIT with 5 queued; then flush together with a write
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h80 + i));
        ticks(2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_count", 32'(bus.fifo_count), 32'd0);
        trig_times.delete();
        ticks(30);
        check("flush_no_trigger", 32'(trig_times.size()), 32'd0);
        bus.flush    = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h99;
        tick();
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        check("flush_write_count", 32'(bus.fifo_count), 32'd0);
        check("flush_write_ovf", 32'(bus.overflow), 32'd0);
        ticks(5);
        compare_rx("flush");

        // Random traffic, which also wraps the pointers many times
        for (int i = 0; i < 800; i++) begin
            bus.wr_valid = ($urandom_range(0, 9) < 2);
            bus.wr_data  = 8'($urandom);
            bus.ovf_clr  = ($urandom_range(0, 19) == 0);
            bus.flush    = ($urandom_range(0, 149) == 0);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.ovf_clr  = 1'b0;
        bus.flush    = 1'b0;
        ticks(DEPTH * 24 + 30);
        compare_rx("rand");

        // Asynchronous reset in the middle of WAIT with bytes still queued
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
        ticks(5);
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_tx_data",  32'(bus.tx_data),    32'h00);
        check("arst_trigger",  32'(bus.trigger),    32'd0);
        check("arst_busy",     32'(bus.busy),       32'd0);
        check("arst_count",    32'(bus.fifo_count), 32'd0);
        check("arst_wr_ready", 32'(bus.wr_ready),   32'd1);
        check("arst_overflow", 32'(bus.overflow),   32'd0);
        ticks(3);
        rst_n = 1'b0;
        trig_times.delete();
        ticks(40);
        check("post_reset_no_trigger", 32'(trig_times.size()), 32'd0);
        push_byte(8'h5A);
        ticks(30);
        check("post_reset_trigger", 32'(trig_times.size()), 32'd1);
        compare_rx("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
